dac_ramp_gen: RTL and testbench

Sawtooth ramp sequencer that produces the 8-bit sample code for the parallel DAC driver stage. It sits directly upstream of that driver; its registered `dac_code` output feeds the driver's data bus. The driver already presents the bus to the converter on the inverted clock. The block holds a park code when idle. On command it emits a configured number of stepped ramps (start → stop, fixed step, fixed dwell per step, optional gap between ramps), used as the radar tuning waveform.

---
 rtl/dac_pkg.sv | 21 ++
 rtl/dac_tick_cnt.sv | 42 ++++
 rtl/dac_ramp_gen.sv | 236 +++++++++++++++++++++++
 tb/tb_dac_ramp_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// -----------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the DAC ramp sequencer. It holds the sequencer state
// encoding and the default code/counter widths and park code that the
// dac_ramp_gen parameters pick up.
// -----------------------------------------------------------------------------
package dac_pkg;

  // Default sample code width, dwell/gap/ramp-count width and idle code.
  localparam int unsigned DAC_DW        = 8;
  localparam int unsigned DAC_CW        = 16;
  localparam int unsigned DAC_PARK_CODE = 178;

  // Sequencer states. The explicit values keep the legacy two-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/dac_tick_cnt.sv
// -----------------------------------------------------------------------------
// dac_tick_cnt
// Load / terminal-count down counter. It is used for both the per-code dwell
// and the inter-ramp gap. Loading N-1 makes tc rise on the N-th cycle after
// the load, so the owning state lasts exactly N cycles.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   load      in   load load_val (has priority over en)
//   load_val  in   CW-bit value to load (terminal count minus one)
//   en        in   count down by one per cycle while non-zero
//   tc        out  terminal count: counter is at zero
// -----------------------------------------------------------------------------
module dac_tick_cnt
  import dac_pkg::*;
#(
  parameter int unsigned CW = DAC_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          tc
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/dac_ramp_gen.sv
// -----------------------------------------------------------------------------
// dac_ramp_gen
// Sawtooth ramp sequencer that feeds the parallel DAC driver. While idle it
// holds PARK_CODE. When it receives start, it plays cfg_nramps stepped ramps
// (0 = run until abort). Each ramp goes from cfg_start to cfg_stop in steps
// of cfg_step, holds every code for cfg_dwell clocks, and leaves cfg_gap
// clocks (at cfg_start) between ramps. All outputs are registered.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   cfg_start   in   first code of each ramp
//   cfg_stop    in   final code of each ramp
//   cfg_step    in   code increment per step (0 behaves as 1)
//   cfg_dwell   in   clocks per code (0 behaves as 1)
//   cfg_gap     in   idle clocks between ramps (0 = back-to-back)
//   cfg_nramps  in   ramps per run (0 = continuous)
//   start       in   run request, honoured only in IDLE
//   abort       in   stop request, any state; wins over start
//   dac_code    out  sample code to the DAC driver
//   ramp_sync   out  pulse on the first sample of each ramp
//   busy        out  high in RAMP or GAP
//   done        out  pulse when a finite run completes (not on abort)
//   cfg_err     out  pulse when start is rejected for cfg_start >= cfg_stop
// -----------------------------------------------------------------------------
module dac_ramp_gen
  import dac_pkg::*;
#(
  parameter int unsigned DW        = DAC_DW,
  parameter int unsigned CW        = DAC_CW,
  parameter int unsigned PARK_CODE = DAC_PARK_CODE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] cfg_start,
  input  logic [DW-1:0] cfg_stop,
  input  logic [DW-1:0] cfg_step,
  input  logic [CW-1:0] cfg_dwell,
  input  logic [CW-1:0] cfg_gap,
  input  logic [CW-1:0] cfg_nramps,
  input  logic          start,
  input  logic          abort,
  output logic [DW-1:0] dac_code,
  output logic          ramp_sync,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  localparam logic [DW-1:0] PARK = DW'(PARK_CODE);

  state_t state_q, state_d;

  // Run configuration that was captured when the run was accepted.
  logic [DW-1:0] sh_start, sh_stop, sh_step;
  logic [CW-1:0] sh_dwell_m1, sh_gap, sh_nramps;

  logic [CW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [DW-1:0] code_d;
  logic          sync_d, done_d, err_d;
  logic          latch_cfg;

  logic          dwell_load, dwell_tc;
  logic [CW-1:0] dwell_load_val;
  logic          gap_load, gap_tc;

  // Live inputs with the zero substitutions applied. They are used only in
  // the accepting cycle.
  logic [DW-1:0] in_step;
  logic [CW-1:0] in_dwell_m1;
  logic          cfg_ok;

  assign in_step     = (cfg_step == '0) ? DW'(1) : cfg_step;
  assign in_dwell_m1 = (cfg_dwell == '0) ? '0 : cfg_dwell - CW'(1);
  assign cfg_ok      = (cfg_start < cfg_stop);

  // The next code is computed one bit wider, so an overshoot past the stop
  // code clamps to the stop code instead of wrapping around.
  logic [DW:0]   code_sum;
  logic [DW-1:0] code_next;
  logic          at_stop;

  assign code_sum  = {1'b0, dac_code} + {1'b0, sh_step};
  assign code_next = (code_sum >= {1'b0, sh_stop}) ? sh_stop : code_sum[DW-1:0];
  assign at_stop   = (dac_code == sh_stop);

  // The ramp count saturates, so continuous mode never wraps it into a
  // spurious match against a non-zero count.
  logic [CW-1:0] ramp_cnt_inc;
  logic          last_ramp;

  assign ramp_cnt_inc = (ramp_cnt_q == '1) ? ramp_cnt_q : ramp_cnt_q + CW'(1);
  assign last_ramp    = (sh_nramps != '0) && (ramp_cnt_inc == sh_nramps);

  dac_tick_cnt #(.CW(CW)) u_dwell_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dwell_load),
    .load_val (dwell_load_val),
    .en       (state_q == ST_RAMP),
    .tc       (dwell_tc)
  );

  dac_tick_cnt #(.CW(CW)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (sh_gap - CW'(1)),
    .en       (state_q == ST_GAP),
    .tc       (gap_tc)
  );

  always_comb begin
    state_d        = state_q;
    code_d         = dac_code;
    sync_d         = 1'b0;
    done_d         = 1'b0;
    err_d          = 1'b0;
    ramp_cnt_d     = ramp_cnt_q;
    latch_cfg      = 1'b0;
    dwell_load     = 1'b0;
    dwell_load_val = sh_dwell_m1;
    gap_load       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        code_d = PARK;
        if (start && !abort) begin
          if (cfg_ok) begin
            // The shadow registers are not valid yet, so the first sample
            // and its dwell come straight from the live inputs.
            latch_cfg      = 1'b1;
            state_d        = ST_RAMP;
            code_d         = cfg_start;
            sync_d         = 1'b1;
            ramp_cnt_d     = '0;
            dwell_load     = 1'b1;
            dwell_load_val = in_dwell_m1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_RAMP: begin
        if (dwell_tc) begin
          if (!at_stop) begin
            code_d     = code_next;
            dwell_load = 1'b1;
          end else begin
            ramp_cnt_d = ramp_cnt_inc;
            if (last_ramp) begin
              state_d = ST_IDLE;
              code_d  = PARK;
              done_d  = 1'b1;
            end else if (sh_gap == '0) begin
              code_d     = sh_start;
              sync_d     = 1'b1;
              dwell_load = 1'b1;
            end else begin
              state_d  = ST_GAP;
              code_d   = sh_start;
              gap_load = 1'b1;
            end
          end
        end
      end

      ST_GAP: begin
        // dac_code already holds the start code. The new ramp begins with a
        // full dwell on that same code.
        if (gap_tc) begin
          state_d    = ST_RAMP;
          sync_d     = 1'b1;
          dwell_load = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        code_d  = PARK;
      end
    endcase

    // Abort overrides everything above, including a start in the same cycle.
    if (abort) begin
      state_d    = ST_IDLE;
      code_d     = PARK;
      sync_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      latch_cfg  = 1'b0;
      dwell_load = 1'b0;
      gap_load   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dac_code   <= PARK;
      ramp_sync  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      ramp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dac_code   <= code_d;
      ramp_sync  <= sync_d;
      busy       <= (state_d != ST_IDLE);
      done       <= done_d;
      cfg_err    <= err_d;
      ramp_cnt_q <= ramp_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_start    <= '0;
      sh_stop     <= '0;
      sh_step     <= DW'(1);
      sh_dwell_m1 <= '0;
      sh_gap      <= '0;
      sh_nramps   <= '0;
    end else if (latch_cfg) begin
      sh_start    <= cfg_start;
      sh_stop     <= cfg_stop;
      sh_step     <= in_step;
      sh_dwell_m1 <= in_dwell_m1;
      sh_gap      <= cfg_gap;
      sh_nramps   <= cfg_nramps;
    end
  end

endmodule

// File: tb/tb_dac_ramp_gen.sv
// -----------------------------------------------------------------------------
// tb_dac_ramp_gen
// Directed bench for dac_ramp_gen. Expected samples are queued when a run is
// started and popped one per clock as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_dac_ramp_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cfg_start, cfg_stop, cfg_step;
  logic [15:0] cfg_dwell, cfg_gap, cfg_nramps;
  logic        start, abort;
  logic [7:0]  dac_code;
  logic        ramp_sync, busy, done, cfg_err;

  dac_ramp_gen #(.DW(8), .CW(16), .PARK_CODE(178)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_stop   (cfg_stop),
    .cfg_step   (cfg_step),
    .cfg_dwell  (cfg_dwell),
    .cfg_gap    (cfg_gap),
    .cfg_nramps (cfg_nramps),
    .start      (start),
    .abort      (abort),
    .dac_code   (dac_code),
    .ramp_sync  (ramp_sync),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic [3:0] flags;  // {ramp_sync, busy, done, cfg_err}
  } exp_t;

  exp_t  exp_q[$];
  int    n_pass = 0;
  int    n_fail = 0;
  int    n_smp  = 0;
  string phase  = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s/%s: got %0h want %0h", phase, tag, got, want);
    end
  endtask

  task automatic push(input int code, input logic s, input logic b, input logic d, input logic e);
    exp_t x;
    x.code  = 8'(code);
    x.flags = {s, b, d, e};
    exp_q.push_back(x);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(178, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One ramp: each code is held dw cycles, the step is clamped at sp, and
  // ramp_sync is set only on the very first sample.
  task automatic push_ramp(input int st, input int sp, input int stp, input int dw);
    int c;
    c = st;
    for (int k = 0; k < 300; k++) begin
      for (int d = 0; d < dw; d++) push(c, (k == 0 && d == 0), 1'b1, 1'b0, 1'b0);
      if (c == sp) break;
      c = (c + stp > sp) ? sp : c + stp;
    end
  endtask

  task automatic push_gap(input int st, input int n);
    for (int i = 0; i < n; i++) push(st, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pop();
    exp_t x;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s/queue: got empty want entry", phase);
    end else begin
      x = exp_q.pop_front();
      chk($sformatf("code[%0d]", n_smp), 32'(dac_code), 32'(x.code));
      chk($sformatf("flags[%0d]", n_smp), 32'({ramp_sync, busy, done, cfg_err}), 32'(x.flags));
      n_smp++;
    end
  endtask

  // One clock per queued sample. Single-cycle requests are dropped after the
  // first edge.
  task automatic run_queue();
    while (exp_q.size() != 0) begin
      step();
      start = 1'b0;
      abort = 1'b0;
      check_pop();
    end
  endtask

  task automatic set_cfg(input int st, input int sp, input int stp, input int dw,
                         input int gp, input int nr);
    cfg_start  = 8'(st);
    cfg_stop   = 8'(sp);
    cfg_step   = 8'(stp);
    cfg_dwell  = 16'(dw);
    cfg_gap    = 16'(gp);
    cfg_nramps = 16'(nr);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;

    phase = "reset_idle";
    push_idle(6);
    run_queue();

    phase = "two_ramps";
    set_cfg(10, 20, 4, 2, 3, 2);
    push_ramp(10, 20, 4, 2);
    push_gap(10, 3);
    push_ramp(10, 20, 4, 2);
    push(178, 1'b0, 1'b0, 1'b1, 1'b0);
    push_idle(2);
    start = 1'b1;
    run_queue();

    phase = "continuous";
    set_cfg(0, 255, 200, 1, 0, 0);
    for (int r = 0; r < 3; r++) push_ramp(0, 255, 200, 1);
    start = 1'b1;
    run_queue();
    abort = 1'b1;
    push_idle(3);
    run_queue();

    phase = "cfg_err";
    set_cfg(50, 50, 1, 1, 0, 1);
    push(178, 1'b0, 1'b0, 1'b0, 1'b1);
    push_idle(2);
    start = 1'b1;
    run_queue();

    phase = "zero_step_dwell";
    set_cfg(5, 9, 0, 0, 0, 1);
    push_ramp(5, 9, 1, 1);
    push(178, 1'b0, 1'b0, 1'b1, 1'b0);
    push_idle(1);
    start = 1'b1;
    run_queue();

    phase = "cfg_change";
    set_cfg(10, 20, 4, 2, 3, 2);
    push_ramp(10, 20, 4, 2);
    push_gap(10, 3);
    push_ramp(10, 20, 4, 2);
    push(178, 1'b0, 1'b0, 1'b1, 1'b0);
    push_idle(1);
    start = 1'b1;
    step();
    start = 1'b0;
    check_pop();
    set_cfg(1, 200, 7, 5, 9, 7);
    start = 1'b1;
    run_queue();

    phase = "abort_and_start";
    set_cfg(10, 20, 4, 2, 3, 2);
    start = 1'b1;
    abort = 1'b1;
    push_idle(3);
    run_queue();

    phase = "reset_mid_ramp";
    set_cfg(10, 20, 4, 2, 0, 0);
    push_ramp(10, 20, 4, 2);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      start = 1'b0;
      check_pop();
    end
    exp_q.delete();
    rst_n = 1'b0;
    #2;
    chk("async_code", 32'(dac_code), 32'd178);
    chk("async_flags", 32'({ramp_sync, busy, done, cfg_err}), 32'd0);
    step();
    rst_n = 1'b1;
    push_idle(4);
    run_queue();

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
